// File: rtl/hashmap_pkg.sv
// Shared types and entry-layout helpers for the hashmap update stage.
// Entry layout, MSB to LSB: {occupied, key, value}.
package hashmap_pkg;

  typedef enum logic [1:0] {
    INSERT    = 2'd0,
    HIT       = 2'd1,
    COLLISION = 2'd2
  } status_t;

  function automatic int entry_width(input int key_w, input int value_w);
    return 1 + key_w + value_w;
  endfunction

  // Field positions used to pack and unpack an entry.
  function automatic int occ_bit(input int key_w, input int value_w);
    return key_w + value_w;
  endfunction

  function automatic int key_lsb(input int value_w);
    return value_w;
  endfunction

  function automatic int value_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/hashmap_fwd_window.sv
// History of the last DEPTH issued bucket writes with a youngest-match lookup,
// covering writes the RAM read pipeline cannot yet observe.
module hashmap_fwd_window #(
  parameter int DEPTH       = 2,
  parameter int ADDR_WIDTH  = 10,
  parameter int ENTRY_WIDTH = 49
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  input  logic [ADDR_WIDTH-1:0]  push_addr,
  input  logic [ENTRY_WIDTH-1:0] push_entry,
  input  logic [ADDR_WIDTH-1:0]  lookup_addr,
  output logic                   lookup_hit,
  output logic [ENTRY_WIDTH-1:0] lookup_entry
);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_d  [DEPTH];
  logic [ENTRY_WIDTH-1:0] entry_q [DEPTH];
  logic [ENTRY_WIDTH-1:0] entry_d [DEPTH];

  // Slot 0 is the youngest write; every cycle shifts, bubbles push invalid slots.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    valid_d[0] = push_valid;
    addr_d[0]  = push_addr;
    entry_d[0] = push_entry;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
      entry_d[i] = entry_q[i-1];
    end
  end

  // NOTE: sequential blocks use non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: payload storage is deliberately not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    entry_q <= entry_d;
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_entry = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
        lookup_hit   = 1'b1;
        lookup_entry = entry_q[i];
      end
    end
  end

endmodule

// File: rtl/hashmap_update.sv
// Read-modify-write bucket stage turning pre-hashed keys into occurrence counts.
// Optional statistics counters are enabled by defining HASHMAP_UPDATE_STATS_EN.
module hashmap_update
  import hashmap_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_PIPES   = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  input  logic [KEY_WIDTH-1:0]                          in_key,
  input  logic [ADDR_WIDTH-1:0]                         in_addr,
  output logic [ADDR_WIDTH-1:0]                         ram_read_addr,
  input  logic [entry_width(KEY_WIDTH, VALUE_WIDTH)-1:0] ram_read_val,
  output logic                                          ram_write_en,
  output logic [ADDR_WIDTH-1:0]                         ram_write_addr,
  output logic [entry_width(KEY_WIDTH, VALUE_WIDTH)-1:0] ram_write_val,
  output logic                                          out_valid,
  output logic [KEY_WIDTH-1:0]                          out_key,
  output logic [VALUE_WIDTH-1:0]                        out_value,
  output logic [1:0]                                    out_status
`ifdef HASHMAP_UPDATE_STATS_EN
  ,
  output logic [31:0]                                   stat_inserts,
  output logic [31:0]                                   stat_hits,
  output logic [31:0]                                   stat_collisions
`endif
);

  localparam int L       = NUM_PIPES + 1;
  localparam int E       = entry_width(KEY_WIDTH, VALUE_WIDTH);
  localparam int OCC_BIT = occ_bit(KEY_WIDTH, VALUE_WIDTH);
  localparam int KEY_LSB = key_lsb(VALUE_WIDTH);
  localparam int VAL_LSB = value_lsb();
  localparam logic [VALUE_WIDTH-1:0] VALUE_ONE = VALUE_WIDTH'(1);
  localparam logic [VALUE_WIDTH-1:0] VALUE_MAX = '1;

  logic [L-1:0]          req_valid_q, req_valid_d;
  logic [KEY_WIDTH-1:0]  req_key_q  [L];
  logic [KEY_WIDTH-1:0]  req_key_d  [L];
  logic [ADDR_WIDTH-1:0] req_addr_q [L];
  logic [ADDR_WIDTH-1:0] req_addr_d [L];

  logic                   c_valid;
  logic [KEY_WIDTH-1:0]   c_key;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic                   fwd_hit;
  logic [E-1:0]           fwd_entry, cur_entry, new_entry;
  logic [VALUE_WIDTH-1:0] cur_value, value_c;
  status_t                status_c;
  logic                   write_c;

  logic                   out_valid_q, out_valid_d;
  logic [KEY_WIDTH-1:0]   out_key_q, out_key_d;
  logic [VALUE_WIDTH-1:0] out_value_q, out_value_d;
  status_t                out_status_q, out_status_d;
  logic                   ram_write_en_q, ram_write_en_d;
  logic [ADDR_WIDTH-1:0]  ram_write_addr_q, ram_write_addr_d;
  logic [E-1:0]           ram_write_val_q, ram_write_val_d;

  assign ram_read_addr = in_addr;

  // Request pipeline depth matches the RAM read latency.
  always_comb begin
    req_valid_d[0] = in_valid;
    req_key_d[0]   = in_key;
    req_addr_d[0]  = in_addr;
    for (int i = 1; i < L; i++) begin
      req_valid_d[i] = req_valid_q[i-1];
      req_key_d[i]   = req_key_q[i-1];
      req_addr_d[i]  = req_addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_valid_q <= '0;
    else        req_valid_q <= req_valid_d;
  end

  always_ff @(posedge clk) begin
    req_key_q  <= req_key_d;
    req_addr_q <= req_addr_d;
  end

  assign c_valid = req_valid_q[L-1];
  assign c_key   = req_key_q[L-1];
  assign c_addr  = req_addr_q[L-1];

  // Window slot 0 mirrors the write currently on the RAM port.
  hashmap_fwd_window #(
    .DEPTH       (L + 1),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .ENTRY_WIDTH (E)
  ) u_fwd_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid   (write_c),
    .push_addr    (c_addr),
    .push_entry   (new_entry),
    .lookup_addr  (c_addr),
    .lookup_hit   (fwd_hit),
    .lookup_entry (fwd_entry)
  );

  always_comb begin
    cur_entry = fwd_hit ? fwd_entry : ram_read_val;
    cur_value = cur_entry[VAL_LSB +: VALUE_WIDTH];
    status_c  = INSERT;
    value_c   = VALUE_ONE;
    if (cur_entry[OCC_BIT]) begin
      if (cur_entry[OCC_BIT-1:KEY_LSB] == c_key) begin
        status_c = HIT;
        value_c  = (cur_value == VALUE_MAX) ? cur_value : cur_value + VALUE_ONE;
      end else begin
        status_c = COLLISION;
        value_c  = cur_value;
      end
    end
    write_c   = c_valid && (status_c != COLLISION);
    new_entry = {1'b1, c_key, value_c};

    out_valid_d      = c_valid;
    out_key_d        = c_valid ? c_key    : out_key_q;
    out_value_d      = c_valid ? value_c  : out_value_q;
    out_status_d     = c_valid ? status_c : out_status_q;
    ram_write_en_d   = write_c;
    ram_write_addr_d = write_c ? c_addr    : ram_write_addr_q;
    ram_write_val_d  = write_c ? new_entry : ram_write_val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_key_q        <= '0;
      out_value_q      <= '0;
      out_status_q     <= INSERT;
      ram_write_en_q   <= 1'b0;
      ram_write_addr_q <= '0;
      ram_write_val_q  <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_key_q        <= out_key_d;
      out_value_q      <= out_value_d;
      out_status_q     <= out_status_d;
      ram_write_en_q   <= ram_write_en_d;
      ram_write_addr_q <= ram_write_addr_d;
      ram_write_val_q  <= ram_write_val_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_key        = out_key_q;
  assign out_value      = out_value_q;
  assign out_status     = out_status_q;
  assign ram_write_en   = ram_write_en_q;
  assign ram_write_addr = ram_write_addr_q;
  assign ram_write_val  = ram_write_val_q;

`ifdef HASHMAP_UPDATE_STATS_EN
  logic [31:0] stat_inserts_q, stat_inserts_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_collisions_q, stat_collisions_d;

  // Counted on the cycle the result is presented; wraps naturally at 2^32.
  always_comb begin
    stat_inserts_d    = stat_inserts_q;
    stat_hits_d       = stat_hits_q;
    stat_collisions_d = stat_collisions_q;
    if (out_valid_q) begin
      case (out_status_q)
        INSERT:    stat_inserts_d    = stat_inserts_q + 32'd1;
        HIT:       stat_hits_d       = stat_hits_q + 32'd1;
        COLLISION: stat_collisions_d = stat_collisions_q + 32'd1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_inserts_q    <= '0;
      stat_hits_q       <= '0;
      stat_collisions_q <= '0;
    end else begin
      stat_inserts_q    <= stat_inserts_d;
      stat_hits_q       <= stat_hits_d;
      stat_collisions_q <= stat_collisions_d;
    end
  end

  assign stat_inserts    = stat_inserts_q;
  assign stat_hits       = stat_hits_q;
  assign stat_collisions = stat_collisions_q;
`endif

endmodule

// File: tb/tb_hashmap_update.sv
// Scoreboard bench: four DUTs (NUM_PIPES 0..3) share one stimulus stream and are
// checked against a sequential bucket model, each with its own bench RAM.
module tb_hashmap_update;

  localparam int AW = 10, KW = 32, VW = 16, E = 1 + KW + VW, N_INST = 4;
  localparam int SAT_ADDR = 20;
  localparam logic [KW-1:0] SAT_KEY = 32'h5A70_0001;
  localparam logic [1:0] ST_INSERT = 2'd0, ST_HIT = 2'd1, ST_COLL = 2'd2;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [1:0]    status;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [KW-1:0] in_key = '0;
  logic [AW-1:0] in_addr = '0;

  logic [N_INST-1:0] out_valid_a, we_a;
  logic [KW-1:0]     out_key_a    [N_INST];
  logic [VW-1:0]     out_value_a  [N_INST];
  logic [1:0]        out_status_a [N_INST];
  logic [AW-1:0]     waddr_a      [N_INST];
  logic [E-1:0]      wval_a       [N_INST];
`ifdef HASHMAP_UPDATE_STATS_EN
  logic [31:0]       si_a [N_INST];
  logic [31:0]       sh_a [N_INST];
  logic [31:0]       sc_a [N_INST];
`endif

  exp_t exp_q [N_INST][$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain per-bucket state, updated in request order.
  bit          m_occ [1024];
  logic [KW-1:0] m_key [1024];
  int unsigned m_val [1024];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [AW-1:0] rd_addr;
    logic [E-1:0]  rd_pipe [LAT];
    logic [E-1:0]  mem [1024];
    bit            loaded = 1'b0;

    // Bench RAM: read-old-data on same-address read/write, LAT-cycle read latency.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int a = 0; a < 1024; a++) mem[a] <= (a == SAT_ADDR) ? {1'b1, SAT_KEY, 16'hFFFE} : '0;
        loaded <= 1'b1;
      end else begin
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (we_a[g]) mem[waddr_a[g]] <= wval_a[g];
      end
    end

    hashmap_update #(
      .ADDR_WIDTH(AW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_PIPES(g)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_key         (in_key),
      .in_addr        (in_addr),
      .ram_read_addr  (rd_addr),
      .ram_read_val   (rd_pipe[LAT-1]),
      .ram_write_en   (we_a[g]),
      .ram_write_addr (waddr_a[g]),
      .ram_write_val  (wval_a[g]),
      .out_valid      (out_valid_a[g]),
      .out_key        (out_key_a[g]),
      .out_value      (out_value_a[g]),
      .out_status     (out_status_a[g])
`ifdef HASHMAP_UPDATE_STATS_EN
      ,
      .stat_inserts    (si_a[g]),
      .stat_hits       (sh_a[g]),
      .stat_collisions (sc_a[g])
`endif
    );
  end

  // Monitor: pops one expectation per presented result, per instance.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < N_INST; g++) begin
      if (out_valid_a[g]) begin
        if (exp_q[g].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out[p%0d]: got out_valid=1 want no result pending", g);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("key[p%0d]", g), 64'(out_key_a[g]), 64'(e.key));
          check($sformatf("value[p%0d]", g), 64'(out_value_a[g]), 64'(e.value));
          check($sformatf("status[p%0d]", g), 64'(out_status_a[g]), 64'(e.status));
          check($sformatf("write_en[p%0d]", g), 64'(we_a[g]), 64'(e.status != ST_COLL));
          if (e.status != ST_COLL) begin
            check($sformatf("write_addr[p%0d]", g), 64'(waddr_a[g]), 64'(e.addr));
            check($sformatf("write_val[p%0d]", g), 64'(wval_a[g]), 64'({1'b1, e.key, e.value}));
          end
        end
      end else if (we_a[g]) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_write[p%0d]: got write_en=1 addr %0h want no write", g, waddr_a[g]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [KW-1:0] k, input logic [AW-1:0] a);
    exp_t e;
    if (!m_occ[a]) begin
      m_occ[a] = 1'b1;
      m_key[a] = k;
      m_val[a] = 1;
      e.status = ST_INSERT;
    end else if (m_key[a] == k) begin
      if (m_val[a] < 65535) m_val[a] = m_val[a] + 1;
      e.status = ST_HIT;
    end else begin
      e.status = ST_COLL;
    end
    e.key   = k;
    e.addr  = a;
    e.value = VW'(m_val[a]);
    for (int g = 0; g < N_INST; g++) exp_q[g].push_back(e);
    in_valid = 1'b1;
    in_key   = k;
    in_addr  = a;
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < N_INST; g++) begin
      check($sformatf("%s_out_valid[p%0d]", tag, g), 64'(out_valid_a[g]), 64'd0);
      check($sformatf("%s_write_en[p%0d]", tag, g), 64'(we_a[g]), 64'd0);
`ifdef HASHMAP_UPDATE_STATS_EN
      check($sformatf("%s_stat_inserts[p%0d]", tag, g), 64'(si_a[g]), 64'd0);
      check($sformatf("%s_stat_hits[p%0d]", tag, g), 64'(sh_a[g]), 64'd0);
      check($sformatf("%s_stat_collisions[p%0d]", tag, g), 64'(sc_a[g]), 64'd0);
`endif
    end
  endtask

  task automatic check_queues_drained(input string tag);
    for (int g = 0; g < N_INST; g++)
      check($sformatf("%s_pending[p%0d]", tag, g), 64'(exp_q[g].size()), 64'd0);
  endtask

  initial begin
    logic [E-1:0] want;
    for (int a = 0; a < 1024; a++) begin
      m_occ[a] = 1'b0;
      m_key[a] = '0;
      m_val[a] = 0;
    end
    m_occ[SAT_ADDR] = 1'b1;
    m_key[SAT_ADDR] = SAT_KEY;
    m_val[SAT_ADDR] = 32'hFFFE;

    idle(4);
    check_idle_outputs("reset");
    for (int g = 0; g < N_INST; g++) begin
      check($sformatf("reset_out_key[p%0d]", g), 64'(out_key_a[g]), 64'd0);
      check($sformatf("reset_out_value[p%0d]", g), 64'(out_value_a[g]), 64'd0);
      check($sformatf("reset_out_status[p%0d]", g), 64'(out_status_a[g]), 64'd0);
      check($sformatf("reset_write_addr[p%0d]", g), 64'(waddr_a[g]), 64'd0);
      check($sformatf("reset_write_val[p%0d]", g), 64'(wval_a[g]), 64'd0);
    end
    rst_n = 1'b1;
    idle(2);

    send(32'hA, 10'd3);
    idle(6);
    repeat (5) send(32'hC0FF_EE00, 10'd7);
    idle(6);
    send(32'hA, 10'd10);
    send(32'hB, 10'd10);
    idle(6);
    send(SAT_KEY, 10'(SAT_ADDR));
    send(SAT_KEY, 10'(SAT_ADDR));
    idle(6);

    // Same-bucket spacing 1..7 cycles straddles the window edge for every latency.
    for (int gap = 0; gap < 7; gap++) begin
      send(32'h11, 10'd1);
      idle(gap);
      send(32'h11, 10'd1);
      idle(gap);
      send(32'h22, 10'd2);
      idle(gap);
      send(32'h11, 10'd1);
      idle(gap);
      send(32'h22, 10'd2);
      idle(6);
    end

    for (int n = 0; n < 800; n++) begin
      send(32'h100 + 32'($urandom_range(0, 3)), 10'(32 + $urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 4));
    end
    idle(10);
    check_queues_drained("main");

    for (int a = 0; a < 64; a++) begin
      want = m_occ[a] ? {1'b1, m_key[a], VW'(m_val[a])} : '0;
      check($sformatf("ram[p0][%0d]", a), 64'(g_inst[0].mem[a]), 64'(want));
      check($sformatf("ram[p1][%0d]", a), 64'(g_inst[1].mem[a]), 64'(want));
      check($sformatf("ram[p2][%0d]", a), 64'(g_inst[2].mem[a]), 64'(want));
      check($sformatf("ram[p3][%0d]", a), 64'(g_inst[3].mem[a]), 64'(want));
    end

    // Three requests in flight, then reset; only results already due may appear.
    for (int g = 0; g < N_INST; g++) begin
      for (int k = 0; k <= 1 - g; k++) begin
        exp_t e;
        e.key    = 32'hDEAD_0000 + 32'(k);
        e.value  = VW'(1);
        e.status = ST_INSERT;
        e.addr   = 10'(900 + k);
        exp_q[g].push_back(e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_key   = 32'hDEAD_0000 + 32'(k);
      in_addr  = 10'(900 + k);
      idle(1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    idle(3);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    idle(10);
    check_queues_drained("midreset");

    // Bucket contents survive reset.
    send(32'hA, 10'd3);
    idle(8);
    check_queues_drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
